// File: rtl/wb_uart_master_pkg.sv
// wb_uart_master_pkg: command bytes and FSM state encoding for the byte-to-Wishbone master
package wb_uart_master_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP
    } state_t;

endpackage

// File: rtl/wb_uart_master.sv
// wb_uart_master: parses 'W'/'R' byte commands and issues single 32-bit Wishbone classic transfers
//   clk_i/rstn_i         clock, asynchronous active-low reset
//   rx_data_i/rx_valid_i received byte stream (no backpressure)
//   tx_data_o/tx_valid_o/tx_ready_i  response byte stream
//   wbm_*                Wishbone classic master port
//   busy_o               high whenever a command is in progress
module wb_uart_master
    import wb_uart_master_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, next;
    logic          op;
    logic          err;
    logic [1:0]    cnt;
    logic [TW-1:0] tmo;
    logic          cyc;
    logic          tx_valid;
    logic [31:0]   adr;
    logic [31:0]   dat;
    logic          tmo_hit, last, hs;

    assign tmo_hit = tmo == TW'(TIMEOUT - 1);
    assign hs      = tx_valid & tx_ready_i;
    // Writes and errors answer with a single byte; reads send four.
    assign last    = err | op | (cnt == 2'd3);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = rx_valid_i && (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) ? ADDR : IDLE;
            ADDR:    next = rx_valid_i && cnt == 2'd3 ? (op ? DATA : BUS) : ADDR;
            DATA:    next = rx_valid_i && cnt == 2'd3 ? BUS : DATA;
            BUS:     next = wbm_ack_i || tmo_hit ? RESP : BUS;
            RESP:    next = hs && last ? IDLE : RESP;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            op       <= 1'b0;
            err      <= 1'b0;
            cnt      <= 2'd0;
            tmo      <= '0;
            cyc      <= 1'b0;
            tx_valid <= 1'b0;
            adr      <= 32'h0;
            dat      <= 32'h0;
        end else begin
            cyc      <= next == BUS;
            // tx_valid trails entry into RESP by one cycle and drops with the final handshake.
            tx_valid <= state == RESP && next == RESP;
            if (state != BUS)
                tmo <= '0;
            case (state)
                IDLE: if (next == ADDR) begin
                    op  <= rx_data_i == CMD_WRITE;
                    cnt <= 2'd0;
                end
                ADDR: if (rx_valid_i) begin
                    adr <= {adr[23:0], rx_data_i};
                    cnt <= cnt + 2'd1;
                end
                DATA: if (rx_valid_i) begin
                    dat <= {dat[23:0], rx_data_i};
                    cnt <= cnt + 2'd1;
                end
                BUS: begin
                    tmo <= tmo + TW'(1);
                    if (next == RESP)
                        err <= ~wbm_ack_i;
                    if (wbm_ack_i && !op)
                        dat <= wbm_dat_i;
                end
                RESP: if (hs)
                    cnt <= cnt + 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_data_o  = err ? RSP_ERR : op ? RSP_OK : 8'(dat >> {~cnt, 3'b000});
        tx_valid_o = tx_valid;
        wbm_cyc_o  = cyc;
        wbm_stb_o  = cyc;
        wbm_we_o   = cyc & op;
        wbm_sel_o  = cyc ? 4'hF : 4'h0;
        wbm_adr_o  = adr;
        wbm_dat_o  = dat;
        busy_o     = state != IDLE;
    end

endmodule

// File: tb/tb_wb_uart_master.sv
// tb_wb_uart_master: directed table plus randomized commands against a behavioural response model
module tb_wb_uart_master;
    import wb_uart_master_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy_o;

    wb_uart_master #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          ack_wait;
        int          rdy;
        int          exp_cycles;
        int          exp_n;
        logic [7:0]  exp_b0;
    } vec_t;

    int vecs = 0, fails = 0, cycle = 0;
    int ack_wait, rdy_delay, wcnt, hold;
    logic [31:0] rdata;
    int cyc_n, stb_n, first_cyc, last_cyc, first_txv, last_hs;
    logic [31:0] t_adr[$], t_dat[$];
    logic        t_we[$];
    logic [3:0]  t_sel[$];
    logic [7:0]  txq[$];
    logic        prev_stall;
    logic [7:0]  prev_data;
    vec_t        dir[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Response rules: acked iff the slave answers within TIMEOUT cycles of cyc.
    function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                                input logic [31:0] rdat, input int aw, input int rdy);
        vec_t v;
        bit ok;
        ok = aw >= 0 && aw < TO;
        v.we = we; v.adr = adr; v.wdat = wdat; v.rdat = rdat; v.ack_wait = aw; v.rdy = rdy;
        v.exp_cycles = ok ? aw + 1 : TO;
        v.exp_n      = (ok && !we) ? 4 : 1;
        v.exp_b0     = !ok ? 8'h45 : we ? 8'h4B : rdat[31:24];
        return v;
    endfunction

    function automatic logic [7:0] model_byte(input vec_t v, input int i);
        return 8'(v.rdat >> (24 - 8 * i));
    endfunction

    // One bench cycle: inputs change at the negedge and are sampled by the following posedge.
    task automatic run_cycle(input bit rv, input logic [7:0] rb, input int inj);
        @(negedge clk);
        cycle++;
        if (wbm_cyc_o) begin
            if (first_cyc < 0) first_cyc = cycle;
            last_cyc = cycle;
            cyc_n++;
            wbm_ack_i = ack_wait >= 0 && wcnt == ack_wait;
            wcnt++;
            if (wbm_ack_i) begin
                t_adr.push_back(wbm_adr_o);
                t_dat.push_back(wbm_dat_o);
                t_we.push_back(wbm_we_o);
                t_sel.push_back(wbm_sel_o);
            end
        end else begin
            wbm_ack_i = 1'b0;
            wcnt = 0;
        end
        if (wbm_stb_o) stb_n++;
        wbm_dat_i = wbm_ack_i ? rdata : $urandom;
        if (tx_valid_o) begin
            if (first_txv < 0) first_txv = cycle;
            if (prev_stall) check("tx_hold", {24'h0, tx_data_o}, {24'h0, prev_data});
            tx_ready_i = hold >= rdy_delay;
            hold = tx_ready_i ? 0 : hold + 1;
            if (tx_ready_i) begin
                txq.push_back(tx_data_o);
                last_hs = cycle;
            end
            prev_stall = !tx_ready_i;
            prev_data  = tx_data_o;
        end else begin
            tx_ready_i = 1'($urandom_range(0, 1));
            prev_stall = 1'b0;
        end
        if (inj != 0 && busy_o && (inj == 2 || $urandom_range(0, 2) == 0)) begin
            rx_valid_i = 1'b1;
            rx_data_i  = inj == 2 ? CMD_READ : 8'($urandom);
        end else begin
            rx_valid_i = rv;
            rx_data_i  = rv ? rb : 8'($urandom);
        end
    endtask

    task automatic apply(input vec_t v, input int inj);
        logic [7:0] b[$];
        int lb, guard;
        bit acked;
        ack_wait = v.ack_wait; rdata = v.rdat; rdy_delay = v.rdy;
        wcnt = 0; hold = 0; prev_stall = 1'b0;
        cyc_n = 0; stb_n = 0; first_cyc = -1; last_cyc = -1; first_txv = -1; last_hs = -1;
        t_adr.delete(); t_dat.delete(); t_we.delete(); t_sel.delete(); txq.delete();
        b.push_back(v.we ? CMD_WRITE : CMD_READ);
        for (int i = 3; i >= 0; i--) b.push_back(v.adr[i*8 +: 8]);
        if (v.we) for (int i = 3; i >= 0; i--) b.push_back(v.wdat[i*8 +: 8]);
        foreach (b[i]) begin
            if (i > 0 && $urandom_range(0, 3) == 0) run_cycle(1'b0, 8'h00, 0);
            run_cycle(1'b1, b[i], 0);
        end
        lb = cycle;
        guard = 0;
        do begin
            run_cycle(1'b0, 8'h00, inj);
            guard++;
        end while (busy_o && guard < 300);
        check("busy_timeout", {31'h0, busy_o}, 32'h0);
        acked = v.ack_wait >= 0 && v.ack_wait < TO;
        check("txn_count", t_adr.size(), {31'h0, acked});
        if (t_adr.size() > 0) begin
            check("adr", t_adr[0], v.adr);
            check("we", {31'h0, t_we[0]}, {31'h0, v.we});
            check("sel", {28'h0, t_sel[0]}, 32'hF);
            if (v.we) check("wdat", t_dat[0], v.wdat);
        end
        check("cyc_cycles", cyc_n, v.exp_cycles);
        check("stb_cycles", stb_n, v.exp_cycles);
        check("cyc_rise", first_cyc, lb + 1);
        check("txv_rise", first_txv, last_cyc + 2);
        check("busy_fall", cycle, last_hs + 1);
        check("rsp_len", txq.size(), v.exp_n);
        if (txq.size() > 0) check("rsp_b0", {24'h0, txq[0]}, {24'h0, v.exp_b0});
        for (int i = 1; i < txq.size() && i < 4; i++)
            check("rsp_byte", {24'h0, txq[i]}, {24'h0, model_byte(v, i)});
        check("sel_idle", {28'h0, wbm_sel_o}, 32'h0);
    endtask

    initial begin
        dir[0] = '{1'b1, 32'h30010004, 32'hDEADBEEF, 32'h0,        2,  0, 3, 1, 8'h4B};
        dir[1] = '{1'b0, 32'h30010008, 32'h0,        32'h12345678, 0,  3, 1, 4, 8'h12};
        dir[2] = '{1'b0, 32'h30010010, 32'h0,        32'h0,        -1, 1, 4, 1, 8'h45};
        dir[3] = '{1'b1, 32'h00000020, 32'h01020304, 32'h0,        3,  0, 4, 1, 8'h4B};
        dir[4] = '{1'b0, 32'hFFFFFFFC, 32'h0,        32'hA5C30F96, 3,  0, 4, 4, 8'hA5};
        dir[5] = '{1'b1, 32'h00000040, 32'h55AA55AA, 32'h0,        4,  2, 4, 1, 8'h45};

        rstn_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00; tx_ready_i = 1'b0;
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        ack_wait = -1; rdy_delay = 0; wcnt = 0; hold = 0; prev_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
        check("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        check("rst_stb", {31'h0, wbm_stb_o}, 32'h0);
        check("rst_we", {31'h0, wbm_we_o}, 32'h0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_dat", wbm_dat_o, 32'h0);
        check("rst_sel", {28'h0, wbm_sel_o}, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        rstn_i = 1'b1;

        for (int i = 0; i < 6; i++) apply(dir[i], 0);

        run_cycle(1'b1, 8'h00, 0);
        run_cycle(1'b1, 8'hFF, 0);
        run_cycle(1'b1, 8'h41, 0);
        apply(dir[0], 0);

        apply(mk(1'b0, 32'h10000000, 32'h0, 32'hCAFEF00D, 3, 2), 2);
        apply(mk(1'b1, 32'h10000004, 32'h87654321, 32'h0, 1, 1), 1);

        ack_wait = -1;
        run_cycle(1'b1, CMD_READ, 0);
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 8'(i + 1), 0);
        run_cycle(1'b0, 8'h00, 0);
        run_cycle(1'b0, 8'h00, 0);
        check("pre_rst_cyc", {31'h0, wbm_cyc_o}, 32'h1);
        #2 rstn_i = 1'b0;
        #1;
        check("arst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        check("arst_stb", {31'h0, wbm_stb_o}, 32'h0);
        check("arst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
        check("arst_busy", {31'h0, busy_o}, 32'h0);
        rx_valid_i = 1'b0;
        wbm_ack_i  = 1'b0;
        @(negedge clk);
        rstn_i = 1'b1;
        apply(mk(1'b0, 32'h20000000, 32'h0, 32'h0BADC0DE, 1, 1), 0);

        for (int n = 0; n < 24; n++)
            apply(mk(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                     int'($urandom_range(0, 5)) - 1, int'($urandom_range(0, 3))),
                  int'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/wb_uart_master.md
# wb_uart_master

Byte-stream-to-Wishbone initiator: parses a simple read/write command protocol arriving as bytes from a UART receiver and issues single 32-bit Wishbone classic transactions on the user-area bus. It returns acknowledgements or read data as bytes to a UART transmitter. It is the bus-master counterpart of the UART peripheral slave and serves as a host debug/program-load port. Serial PHYs sit outside this block; it sees bytes only.

## Interface
- `TIMEOUT`, 255 — cycles to wait for `wbm_ack_i` before aborting; range 1..65535.
- `clk_i`  in  1  system clock; the only clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `rx_data_i`  in  8  received byte.
- `rx_valid_i`  in  1  one-cycle strobe qualifying `rx_data_i`; no backpressure.
- `tx_data_o`  out  8  byte to transmit.
- `tx_valid_o`  out  1  `tx_data_o` valid; held until accepted.
- `tx_ready_i`  in  1  transmitter accepts the byte when `tx_valid_o & tx_ready_i`.
- `wbm_cyc_o`, `wbm_stb_o`  out  1  Wishbone cycle/strobe, always equal.
- `wbm_we_o`  out  1  write enable.
- `wbm_adr_o`  out  32  byte address as received, unmodified.
- `wbm_dat_o`  out  32  write data.
- `wbm_sel_o`  out  4  constant 4'hF while `cyc` is high, 0 otherwise.
- `wbm_ack_i`  in  1  slave acknowledge.
- `wbm_dat_i`  in  32  read data, sampled on ack.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- Command format, multi-byte fields MSB first:
  - 0x57 'W': then 4 address bytes, then 4 data bytes.
  - 0x52 'R': then 4 address bytes.
- FSM states: IDLE, ADDR, DATA, BUS, RESP.
- IDLE: on `rx_valid_i`, 'W' or 'R' latches the op and goes to ADDR with the byte counter at 0. Any other byte is ignored; state stays IDLE.
- ADDR: each valid byte shifts into the address register. After the 4th byte, go to DATA (write) or BUS (read).
- DATA: the 4th byte goes to BUS.
- BUS: `cyc`/`stb`/`we`/`sel` are registered and held until ack or timeout.
  - Read data is latched on the ack cycle.
  - On ack, go to RESP with status OK.
  - On timeout, go to RESP with status ERR.
- RESP: emit the response, one byte per handshake, then return to IDLE.
  - Write OK: 0x4B 'K'.
  - Read OK: 4 data bytes, MSB first.
  - Any ERR: 0x45 'E'.
- Bytes arriving in BUS or RESP are dropped silently; they never alter state.
- Reset asserted mid-operation clears all state immediately, including a live bus cycle.
- Reset values: every output 0; `wbm_sel_o` 0; internal registers 0.

## Timing
- `wbm_cyc_o` rises on the clock edge after the cycle that sampled the final command byte.
- If ack is sampled high at edge N, `cyc`/`stb` are low after edge N. Zero-wait-state slaves give one-cycle strobes.
- `tx_valid_o` rises on the edge after the ack (or timeout) edge.
- Each subsequent byte appears on the edge after the previous handshake; `tx_data_o` is stable while `tx_valid_o & ~tx_ready_i`.
- Timeout counter:
  - Cleared on entry to BUS; increments each cycle `cyc` is high without ack.
  - If the counter reaches `TIMEOUT` with no ack, `cyc` drops on that edge.
  - Ack and timeout in the same cycle resolve as ack.
- `busy_o` falls on the edge that completes the last response handshake. A new command byte in that same cycle is ignored.
- Counter width: `$clog2(TIMEOUT+1)` bits. The byte counter is 2 bits and wraps 3→0.

## Structure
- Package `wb_uart_master_pkg`:
  - Command constants: `CMD_WRITE`=8'h57, `CMD_READ`=8'h52, `RSP_OK`=8'h4B, `RSP_ERR`=8'h45.
  - FSM state enum.
- Single module; no sub-module. The response serializer is part of the RESP state logic, sharing the 2-bit byte counter.

## Test plan
- Write: bytes 57 30 01 00 04 DE AD BE EF, slave acks after 2 wait states.
  - Expect one cycle: adr=0x30010004, dat=0xDEADBEEF, we=1, sel=F.
  - Expect tx 0x4B.
- Read: bytes 52 30 01 00 08, zero-wait ack with `wbm_dat_i`=0x12345678.
  - Expect `stb` high exactly 1 cycle.
  - Expect tx 12,34,56,78 in order, each held under `tx_ready_i` low for 3 cycles.
- Timeout (`TIMEOUT`=4): read with no ack.
  - Expect `cyc` high for exactly 4 cycles, then tx 0x45, then IDLE.
- Ack on the timeout cycle: expect tx 0x4B (write) or data bytes (read), not 0x45.
- Garbage and drops: 00 FF 41 57… → leading bytes ignored and the write completes. Extra bytes injected during BUS/RESP do not change the response or the next command.
- Reset mid-BUS: deassert `rstn_i` while `cyc`=1.
  - Expect `cyc`/`stb`/`tx_valid_o`/`busy_o` low asynchronously.
  - Expect a following clean read to succeed.
